// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared constants and types for the NoC input buffering path.
//               Holds the default flit width, default buffer depth, the idle
//               flit encoding and the FIFO operation encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

  // Default flit width in bits.
  localparam int NOC_DATA_WIDTH = 8;

  // Default number of buffer slots (power of two, >= 2).
  localparam int NOC_DEPTH = 4;

  // A flit of all zeros marks an idle cycle on a link.
  localparam int FLIT_IDLE = 0;

  // FIFO operation for a cycle, encoded as {push, pop}.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/noc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : noc_fifo
// Description : Circular FIFO holding buffered flits. Pointers wrap modulo
//               DEPTH (power of two, so natural overflow wraps). The caller
//               is responsible for never pushing into a full FIFO unless it
//               pops in the same cycle.
// Revision    : 1.0 - initial release
//
// Ports
//   clk    in   1            rising-edge clock
//   rst    in   1            synchronous active-low reset
//   push   in   1            write wdata at the tail this cycle
//   pop    in   1            retire the head this cycle
//   wdata  in   DATA_WIDTH   flit to store
//   rdata  out  DATA_WIDTH   current head (undefined while count == 0)
//   count  out  clog2+1      number of stored flits
// ============================================================================
module noc_fifo
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int DEPTH      = NOC_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  fifo_op_e              w_op;

  assign w_op = fifo_op_e'({push, pop});

  // Storage is never reset; it is only observed through rdata when
  // count != 0, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case (w_op)
        FIFO_PUSH: r_count <= r_count + CNT_W'(1);
        FIFO_POP:  r_count <= r_count - CNT_W'(1);
        default:   r_count <= r_count;
      endcase
    end
  end

  assign rdata = r_mem[r_rptr];
  assign count = r_count;

endmodule : noc_fifo
`default_nettype wire

// File: rtl/input_controller.sv
`default_nettype none
// ============================================================================
// Module      : input_controller
// Description : NoC router input port. Buffers flits from the upstream link
//               in a small FIFO, presents the head flit to the switch, and
//               returns registered backpressure upstream. Flits arriving with
//               the buffer completely full (and no pop) are dropped.
// Revision    : 1.0 - initial release
//
// Configuration macro
//   INPUT_CTRL_DROP_CNT_EN  adds the drop_cnt port and a saturating 8-bit
//                           dropped-flit counter.
//
// Ports
//   clk       in   1           rising-edge clock
//   rst       in   1           synchronous active-low reset
//   Data_in   in   DATA_WIDTH  flit from upstream (0 = idle)
//   full      out  1           registered backpressure to upstream
//   Data_out  out  DATA_WIDTH  head flit to switch (0 when empty)
//   val       out  1           Data_out holds a valid flit
//   ret       in   1           switch backpressure (1 = cannot accept)
//   drop_cnt  out  8           dropped-flit count (macro builds only)
// ============================================================================
module input_controller
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int DEPTH      = NOC_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Data_in,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  val,
  input  logic                  ret
`ifdef INPUT_CTRL_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] c_DEPTH   = CNT_W'(DEPTH);
  // Asserting full one slot early leaves a skid slot for the flit that
  // upstream launches before it sees full.
  localparam logic [CNT_W-1:0] c_FULL_AT = CNT_W'(DEPTH - 1);

  logic [CNT_W-1:0]      w_count;
  logic [CNT_W-1:0]      w_count_next;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_flit;
  logic                  w_val;
  logic                  w_push;
  logic                  w_pop;
  logic                  r_full;

  assign w_flit = (Data_in != DATA_WIDTH'(FLIT_IDLE));
  assign w_val  = (w_count != '0);
  assign w_pop  = w_val & ~ret;
  // A pop in the same cycle frees the slot, so a flit is accepted even at
  // count == DEPTH.
  assign w_push = w_flit & ((w_count < c_DEPTH) | w_pop);

  always_comb begin
    w_count_next = w_count;
    case (fifo_op_e'({w_push, w_pop}))
      FIFO_PUSH: w_count_next = w_count + CNT_W'(1);
      FIFO_POP:  w_count_next = w_count - CNT_W'(1);
      default:   w_count_next = w_count;
    endcase
  end

  noc_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (Data_in),
    .rdata (w_rdata),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_full <= 1'b0;
    end else begin
      r_full <= (w_count_next >= c_FULL_AT);
    end
  end

  assign full     = r_full;
  assign val      = w_val;
  assign Data_out = w_val ? w_rdata : '0;

`ifdef INPUT_CTRL_DROP_CNT_EN
  logic       w_drop;
  logic [7:0] r_drop_cnt;

  assign w_drop = w_flit & (w_count == c_DEPTH) & ~w_pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule : input_controller
`default_nettype wire
